// File: rtl/jtlabrun_ymq.sv
// jtlabrun_ymq: in-order write FIFO + issue scheduler from the 6809 to two jt03 chips; ports: clk, rst, cpu_cen, cen3, ym0_cs, ym1_cs, cpu_rnw, cpu_reg, cpu_dout -> waitn, ym_cs_n, ym_addr, ym_wr_n, ym_din; JTLABRUN_YMQ_STATS_EN adds hw_level, stalls
module jtlabrun_ymq #(
  parameter int AW       = 3,
  parameter int ADDR_GAP = 4,
  parameter int DATA_GAP = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       cen3,
  input  logic       ym0_cs,
  input  logic       ym1_cs,
  input  logic       cpu_rnw,
  input  logic       cpu_reg,
  input  logic [7:0] cpu_dout,
  output logic       waitn,
  output logic [1:0] ym_cs_n,
  output logic       ym_addr,
  output logic       ym_wr_n,
  output logic [7:0] ym_din
`ifdef JTLABRUN_YMQ_STATS_EN
  ,
  output logic [AW:0] hw_level,
  output logic [15:0] stalls
`endif
);
  localparam int AG = ADDR_GAP < 1 ? 1 : ADDR_GAP;
  localparam int DG = DATA_GAP < 1 ? 1 : DATA_GAP;
  localparam int CW = $clog2(DG + 1);
  typedef enum logic [1:0] {IDLE, STROBE, GAP} st_t;
  st_t st_q, st_d;
  logic [9:0] mem [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [CW-1:0] gap_q, gap_d;
  logic chip_q, chip_d, addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic cs, full, empty, push, pop, rd_go;
  assign cs    = ym0_cs | ym1_cs;
  assign full  = cnt_q == (AW+1)'(1 << AW);
  assign empty = cnt_q == '0;
  assign push  = cpu_cen & cs & ~cpu_rnw & ~full;
  assign pop   = cen3 & (st_q == IDLE) & ~empty;
  assign waitn = ~(cs & (cpu_rnw ? (~empty | st_q != IDLE) : full));
  // reads bypass the queue only once every queued write has been issued
  assign rd_go   = ~rst & cs & cpu_rnw & empty & (st_q == IDLE);
  assign ym_cs_n = rd_go ? (ym0_cs ? 2'b10 : 2'b01) : st_q == STROBE ? (chip_q ? 2'b01 : 2'b10) : 2'b11;
  assign ym_wr_n = st_q != STROBE;
  assign ym_addr = rd_go ? cpu_reg : addr_q;
  assign ym_din  = din_q;
  always_comb begin
    st_d = st_q;
    gap_d = gap_q;
    {chip_d, addr_d, din_d} = {chip_q, addr_q, din_q};
    if (cen3) begin
      case (st_q)
        IDLE: if (!empty) begin
          st_d = STROBE;
          {chip_d, addr_d, din_d} = mem[rp_q];
        end
        STROBE: begin
          st_d = GAP;
          gap_d = addr_q ? CW'(DG) : CW'(AG);
        end
        GAP: begin
          gap_d = gap_q - 1'b1;
          st_d = gap_q == CW'(1) ? IDLE : GAP;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      gap_q <= '0;
      {chip_q, addr_q, din_q} <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      gap_q <= gap_d;
      {chip_q, addr_q, din_q} <= {chip_d, addr_d, din_d};
      if (push) begin
        mem[wp_q] <= {~ym0_cs, cpu_reg, cpu_dout};
        wp_q <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
`ifdef JTLABRUN_YMQ_STATS_EN
  logic [AW:0] hw_q;
  logic [15:0] stalls_q;
  assign hw_level = hw_q;
  assign stalls   = stalls_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q <= '0;
      stalls_q <= '0;
    end else begin
      if (cnt_q > hw_q) hw_q <= cnt_q;
      if (cpu_cen && !waitn && !(&stalls_q)) stalls_q <= stalls_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_jtlabrun_ymq.sv
// tb_jtlabrun_ymq: directed self-checking bench for jtlabrun_ymq
module tb_jtlabrun_ymq;
  logic clk = 0, rst = 1, cpu_cen = 0, cen3 = 0, ym0_cs = 0, ym1_cs = 0, cpu_rnw = 1, cpu_reg = 0;
  logic [7:0] cpu_dout = 0;
  logic waitn, ym_addr, ym_wr_n;
  logic [1:0] ym_cs_n;
  logic [7:0] ym_din;
`ifdef JTLABRUN_YMQ_STATS_EN
  logic [3:0] hw_level;
  logic [15:0] stalls;
  int exp_stalls = 0;
`endif
  typedef struct {logic [1:0] csn; logic a; logic [7:0] d; int t;} ev_t;
  ev_t log_q[$];
  int checks = 0, errors = 0, div = 0, t3 = 0;
  bit cen3_en = 1;
  logic w_pre, pre_wrn, pre_a;
  logic [1:0] pre_csn;
  int st, pt, p0;
  logic [1:0] csn;
  logic wrn, ra;

  jtlabrun_ymq dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cen3(cen3), .ym0_cs(ym0_cs), .ym1_cs(ym1_cs),
    .cpu_rnw(cpu_rnw), .cpu_reg(cpu_reg), .cpu_dout(cpu_dout), .waitn(waitn), .ym_cs_n(ym_cs_n),
    .ym_addr(ym_addr), .ym_wr_n(ym_wr_n), .ym_din(ym_din)
`ifdef JTLABRUN_YMQ_STATS_EN
    , .hw_level(hw_level), .stalls(stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clk: cpu_cen every 8 clocks, cen3 every 4 clocks, never together
  task automatic tick();
    ev_t e;
    cpu_cen = (div % 8 == 0);
    cen3 = cen3_en && (div % 4 == 2);
    #1;
    w_pre = waitn; pre_csn = ym_cs_n; pre_wrn = ym_wr_n; pre_a = ym_addr;
    if (cen3 && !ym_wr_n && !rst) begin
      e.csn = ym_cs_n; e.a = ym_addr; e.d = ym_din; e.t = t3;
      log_q.push_back(e);
    end
    @(posedge clk); #1;
    if (cen3) t3++;
    div++;
  endtask

  task automatic wr(input bit c0, input bit c1, input bit r, input logic [7:0] d, input int rel,
                    output int nst, output int npt);
    ym0_cs = c0; ym1_cs = c1; cpu_rnw = 0; cpu_reg = r; cpu_dout = d; nst = 0; npt = -1;
    for (int n = 0; n < 4000; n++) begin
      int tt = t3;
      tick();
      if (cpu_cen) begin
        if (w_pre) begin npt = tt; break; end
        nst++;
        if (nst == rel) cen3_en = 1;
      end
    end
    ym0_cs = 0; ym1_cs = 0; cpu_rnw = 1;
`ifdef JTLABRUN_YMQ_STATS_EN
    exp_stalls += nst;
`endif
    if (npt < 0) begin checks++; errors++; $error("FAIL wr_timeout observed=stuck expected=push"); end
  endtask

  task automatic rd(input bit c0, input bit c1, input bit r, output int nst,
                    output logic [1:0] ocsn, output logic owrn, output logic oa);
    bit done = 0;
    ym0_cs = c0; ym1_cs = c1; cpu_rnw = 1; cpu_reg = r; nst = 0;
    ocsn = 'x; owrn = 'x; oa = 'x;
    for (int n = 0; n < 4000 && !done; n++) begin
      tick();
      if (cpu_cen) begin
        if (w_pre) begin ocsn = pre_csn; owrn = pre_wrn; oa = pre_a; done = 1; end
        else nst++;
      end
    end
    ym0_cs = 0; ym1_cs = 0;
`ifdef JTLABRUN_YMQ_STATS_EN
    exp_stalls += nst;
`endif
    if (!done) begin checks++; errors++; $error("FAIL rd_timeout observed=stuck expected=read"); end
  endtask

  initial begin
    repeat (4) tick();
    chk("rst_waitn", waitn, 1);
    chk("rst_cs_n", ym_cs_n, 2'b11);
    chk("rst_wr_n", ym_wr_n, 1);
    chk("rst_addr", ym_addr, 0);
    chk("rst_din", ym_din, 0);
    rst = 0;
    repeat (8) tick();
    // three chip0 writes: strobes spaced 1 strobe + gap + 1 idle/pop tick
    log_q.delete();
    wr(1, 0, 0, 8'h28, 0, st, p0); chk("w1_stall", st, 0);
    wr(1, 0, 1, 8'hF0, 0, st, pt); chk("w2_stall", st, 0);
    wr(1, 0, 0, 8'h2D, 0, st, pt); chk("w3_stall", st, 0);
    repeat (200) tick();
    chk("seq_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("seq0", {log_q[0].csn, log_q[0].a, log_q[0].d}, {2'b10, 1'b0, 8'h28});
      chk("seq1", {log_q[1].csn, log_q[1].a, log_q[1].d}, {2'b10, 1'b1, 8'hF0});
      chk("seq2", {log_q[2].csn, log_q[2].a, log_q[2].d}, {2'b10, 1'b0, 8'h2D});
      chk("latency", log_q[0].t, p0 + 1);
      chk("gap_addr", log_q[1].t - log_q[0].t, 6);
      chk("gap_data", log_q[2].t - log_q[1].t, 26);
    end
    // fill with issue frozen: 8 fit, the 9th stalls until cen3 frees a slot
    log_q.delete();
    cen3_en = 0;
    for (int i = 0; i < 8; i++) begin
      wr(i % 2 == 0, i % 2 == 1, i[0], 8'h30 + 8'(i), 0, st, pt);
      chk("fill_stall", st, 0);
    end
    wr(1, 0, 0, 8'h38, 3, st, pt);
    chk("full_stall", st, 3);
    repeat (1200) tick();
    chk("fill_count", log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      chk("fill_order", {log_q[i].csn, log_q[i].d}, {(i % 2 == 1) ? 2'b01 : 2'b10, 8'h30 + 8'(i)});
`ifdef JTLABRUN_YMQ_STATS_EN
    chk("hw_level", hw_level, 8);
`endif
    // write chip1 data then read chip1: read waits for the 24-tick data gap
    log_q.delete();
    wr(0, 1, 1, 8'h55, 0, st, pt);
    rd(0, 1, 1, st, csn, wrn, ra);
    chk("rd_stall", st, 12);
    chk("rd_cs_n", csn, 2'b01);
    chk("rd_wr_n", wrn, 1);
    chk("rd_addr", ra, 1);
    chk("rd_prior", log_q.size(), 1);
    // both selects high: chip0 wins
    log_q.delete();
    wr(1, 1, 0, 8'h77, 0, st, pt);
    repeat (60) tick();
    chk("both_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("both_cs_n", {log_q[0].csn, log_q[0].d}, {2'b10, 8'h77});
`ifdef JTLABRUN_YMQ_STATS_EN
    chk("stalls", stalls, 16'(exp_stalls));
`endif
    // reset during a strobe with entries queued
    cen3_en = 0;
    for (int i = 0; i < 5; i++) wr(0, 1, 1, 8'hA0 + 8'(i), 0, st, pt);
    cen3_en = 1;
    for (int n = 0; n < 100 && ym_wr_n; n++) tick();
    chk("pre_rst_strobe", ym_wr_n, 0);
    rst = 1;
    tick();
    chk("rst_mid_cs_n", ym_cs_n, 2'b11);
    chk("rst_mid_wr_n", ym_wr_n, 1);
    rst = 0;
    log_q.delete();
    repeat (400) tick();
    chk("no_stale", log_q.size(), 0);
`ifdef JTLABRUN_YMQ_STATS_EN
    chk("rst_hw", hw_level, 0);
    chk("rst_stalls", stalls, 0);
`endif
    rd(1, 0, 0, st, csn, wrn, ra);
    chk("post_rst_rd_stall", st, 0);
    chk("post_rst_rd_cs_n", csn, 2'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
